// File: rtl/nes_pkg.sv
// Shared NES bus constants and the sprite-DMA state encoding.
// No logic: constants and types only.
// No flow control.
package nes_pkg;

   // CPU-visible register addresses used by the sprite DMA engine.
   localparam logic [15:0] OAMDMA_REG  = 16'h4014;
   localparam logic [15:0] OAMDATA_REG = 16'h2004;

   typedef enum logic [2:0] {
      IDLE,
      HALT,
      ALIGN,
      READ,
      WRITE
   } dma_state_t;

endpackage

// File: rtl/oam_dma.sv
// Sprite DMA: on a CPU write to TRIGGER_ADDR, halts the CPU and copies page {data,00..FF} to DEST_ADDR.
// Latency: rdy drops the cycle after the trigger; 513 or 514 enabled cycles with rdy low depending on parity.
// Backpressure: cpu_en low freezes every register, so the transfer simply stretches.
module oam_dma
   import nes_pkg::*;
#(
   parameter logic [15:0] TRIGGER_ADDR = OAMDMA_REG,
   parameter logic [15:0] DEST_ADDR    = OAMDATA_REG
) (
   input  logic        cpu_clk,
   input  logic        reset,
   input  logic        cpu_en,
   input  logic [15:0] cpu_addr,
   input  logic        cpu_wr_n,
   input  logic [7:0]  cpu_dout,
   input  logic [7:0]  bus_din,
   output logic        rdy,
   output logic        dma_active,
   output logic [15:0] dma_addr,
   output logic        dma_wr_n,
   output logic [7:0]  dma_dout
);

   dma_state_t  state, state_n;
   logic [7:0]  page, page_n;
   logic [7:0]  idx, idx_n;
   logic        parity;
   logic [7:0]  dout_hold;

   logic        rdy_n;
   logic        active_n;
   logic        wr_n_n;
   logic [15:0] addr_n;

   // Next-state decode plus the bus outputs that go with the state being entered,
   // so the registered outputs always line up with the state register.
   always_comb begin
      state_n = state;
      page_n  = page;
      idx_n   = idx;
      case (state)
         IDLE: begin
            if (cpu_addr == TRIGGER_ADDR && !cpu_wr_n) begin
               state_n = HALT;
               page_n  = cpu_dout;
               idx_n   = 8'h00;
            end
         end
         // Odd halt cycle means the next cycle is even: go straight to READ.
         HALT:    state_n = parity ? READ : ALIGN;
         ALIGN:   state_n = READ;
         READ:    state_n = WRITE;
         WRITE: begin
            idx_n   = idx + 8'd1;
            state_n = (idx == 8'hFF) ? IDLE : READ;
         end
         default: state_n = IDLE;
      endcase

      rdy_n    = (state_n == IDLE);
      active_n = (state_n == READ) || (state_n == WRITE);
      wr_n_n   = (state_n != WRITE);
      addr_n   = dma_addr;
      if (state_n == READ) begin
         addr_n = {page_n, idx_n};
      end else if (state_n == WRITE) begin
         addr_n = DEST_ADDR;
      end
   end

   // State, counters and registered bus outputs; nothing moves unless cpu_en is high.
   always_ff @(posedge cpu_clk) begin
      if (reset) begin
         state      <= IDLE;
         page       <= 8'h00;
         idx        <= 8'h00;
         parity     <= 1'b0;
         rdy        <= 1'b1;
         dma_active <= 1'b0;
         dma_wr_n   <= 1'b1;
         dma_addr   <= 16'h0000;
         dout_hold  <= 8'h00;
      end else if (cpu_en) begin
         state      <= state_n;
         page       <= page_n;
         idx        <= idx_n;
         parity     <= ~parity;
         rdy        <= rdy_n;
         dma_active <= active_n;
         dma_wr_n   <= wr_n_n;
         dma_addr   <= addr_n;
         if (state == WRITE) begin
            dout_hold <= bus_din;
         end
      end
   end

   // The synchronous memory returns the READ data during the WRITE cycle itself, so it is
   // forwarded directly then; the hold register keeps the last byte stable afterwards.
   assign dma_dout = (state == WRITE) ? bus_din : dout_hold;

endmodule

// File: tb/tb_oam_dma.sv
// Randomized scoreboard bench for oam_dma with a one-cycle-late synchronous memory model.
// Expected bus cycles and rdy-low lengths are queued at trigger time and popped by a monitor.
// cpu_en is randomly gated in some transfers to exercise the freeze behaviour.
module tb_oam_dma;

   typedef struct {
      logic [15:0] addr;
      logic        wr_n;
      logic [7:0]  dat;
   } bus_ev_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cpu_en = 1'b1;
   logic [15:0] cpu_addr = 16'h0000;
   logic        cpu_wr_n = 1'b1;
   logic [7:0]  cpu_dout = 8'h00;
   logic [7:0]  bus_din = 8'h00;
   logic        rdy;
   logic        dma_active;
   logic [15:0] dma_addr;
   logic        dma_wr_n;
   logic [7:0]  dma_dout;

   int          n_tests = 0;
   int          n_fail = 0;
   int          ecyc = 0;
   int          low_run = 0;
   bit          in_run = 0;
   bit          seen80 = 0;

   bus_ev_t     exp_q[$];
   int          len_q[$];

   oam_dma dut (
      .cpu_clk    (clk),
      .reset      (reset),
      .cpu_en     (cpu_en),
      .cpu_addr   (cpu_addr),
      .cpu_wr_n   (cpu_wr_n),
      .cpu_dout   (cpu_dout),
      .bus_din    (bus_din),
      .rdy        (rdy),
      .dma_active (dma_active),
      .dma_addr   (dma_addr),
      .dma_wr_n   (dma_wr_n),
      .dma_dout   (dma_dout)
   );

   always #5 clk = ~clk;

   // Synchronous memory: returns addr[7:0]^A5 for the address seen at the previous enabled edge.
   always @(posedge clk) begin
      if (cpu_en) begin
         bus_din <= (dma_active ? dma_addr[7:0] : cpu_addr[7:0]) ^ 8'hA5;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Monitor: tracks cycle parity, compares every enabled DMA bus cycle and each rdy-low run.
   always @(negedge clk) begin
      if (reset) begin
         ecyc    = 0;
         low_run = 0;
         in_run  = 0;
      end else begin
         if (cpu_en && dma_active) begin
            check("bus_cycle_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
               bus_ev_t e;
               e = exp_q.pop_front();
               check("bus_addr", dma_addr, e.addr);
               check("bus_wr_n", dma_wr_n, e.wr_n);
               if (!e.wr_n) begin
                  check("write_data", dma_dout, e.dat);
               end else begin
                  check("read_on_even_cycle", ecyc % 2, 0);
                  if (dma_addr[7:0] == 8'h80) seen80 = 1;
               end
            end
         end
         if (!rdy) begin
            in_run = 1;
            if (cpu_en) low_run++;
         end else if (in_run) begin
            check("rdy_run_expected", len_q.size() > 0, 1);
            if (len_q.size() > 0) check("rdy_low_cycles", low_run, len_q.pop_front());
            in_run  = 0;
            low_run = 0;
         end
         if (cpu_en) ecyc++;
      end
   end

   // Issue a $4014 write on a cycle of the requested parity and queue the model's expectations.
   task automatic trigger(input logic [7:0] pg, input int par);
      if ((ecyc % 2) != par) step();
      cpu_en   = 1'b1;
      cpu_addr = 16'h4014;
      cpu_wr_n = 1'b0;
      cpu_dout = pg;
      len_q.push_back(par ? 514 : 513);
      for (int i = 0; i < 256; i++) begin
         bus_ev_t r, w;
         r.addr = {pg, 8'(i)};
         r.wr_n = 1'b1;
         r.dat  = 8'h00;
         w.addr = 16'h2004;
         w.wr_n = 1'b0;
         w.dat  = 8'(i) ^ 8'hA5;
         exp_q.push_back(r);
         exp_q.push_back(w);
      end
      step();
      cpu_wr_n = 1'b1;
      cpu_addr = 16'h0000;
   endtask

   task automatic wait_done(input bit rand_en);
      int k;
      k = 0;
      while ((exp_q.size() != 0 || len_q.size() != 0) && k < 4000) begin
         if (rand_en) cpu_en = 1'($urandom_range(0, 1));
         step();
         k++;
      end
      cpu_en = 1'b1;
      check("transfer_within_budget", k < 4000, 1);
      step();
   endtask

   initial begin
      int k;
      // Reset for two cycles, then check reset values in the first free cycle.
      step();
      step();
      reset = 1'b0;
      @(negedge clk);
      check("reset_rdy", rdy, 1);
      check("reset_active", dma_active, 0);
      check("reset_wr_n", dma_wr_n, 1);
      check("reset_addr", dma_addr, 16'h0000);
      check("reset_dout", dma_dout, 8'h00);
      repeat (3) step();

      // Trigger at even parity.
      trigger(8'h02, 0);
      wait_done(0);

      // Trigger at odd parity, with an ignored second $4014 write mid-transfer.
      trigger(8'h02, 1);
      repeat (20) step();
      cpu_addr = 16'h4014;
      cpu_wr_n = 1'b0;
      cpu_dout = 8'h07;
      step();
      cpu_addr = 16'h0000;
      cpu_wr_n = 1'b1;
      wait_done(0);

      // Reads of $4014 never start a transfer.
      cpu_addr = 16'h4014;
      cpu_wr_n = 1'b1;
      cpu_dout = 8'h05;
      repeat (4) step();
      cpu_addr = 16'h0000;
      @(negedge clk);
      check("read_trig_rdy", rdy, 1);
      check("read_trig_active", dma_active, 0);
      repeat (3) step();

      // Random cpu_en gating at both trigger parities with random pages.
      trigger(8'($urandom_range(0, 255)), 0);
      wait_done(1);
      trigger(8'($urandom_range(0, 255)), 1);
      wait_done(1);

      // Reset in the middle of a transfer.
      seen80 = 0;
      trigger(8'h02, 0);
      k = 0;
      while (!seen80 && k < 2000) begin
         step();
         k++;
      end
      check("reached_idx80", seen80, 1);
      reset = 1'b1;
      exp_q.delete();
      len_q.delete();
      step();
      reset = 1'b0;
      @(negedge clk);
      check("midreset_rdy", rdy, 1);
      check("midreset_active", dma_active, 0);
      check("midreset_wr_n", dma_wr_n, 1);
      repeat (10) step();

      // A fresh transfer after reset starts from the new page.
      trigger(8'h03, 0);
      wait_done(0);
      repeat (5) step();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, %0d failed so far", n_fail);
      $fatal(1, "watchdog");
   end

endmodule
